// File: rtl/simon_seq_engine.sv
// simon_seq_engine: Simon-style memory game controller.
// A free-running LFSR supplies one new colour per round; the stored sequence
// is replayed with timed on/gap phases, then the player's presses are
// checked one element at a time.  State is exported as a one-hot register.
module simon_seq_engine #(
  parameter int          NUM_BTNS       = 4,
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 25_000_000,
  parameter int          GAP_CYCLES     = 12_500_000,
  parameter int          TIMEOUT_CYCLES = 250_000_000,
  parameter int          SCORE_W        = 9,
  parameter logic [15:0] SEED           = 16'hACE1,
  localparam int         CW             = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1,
  localparam int         LW             = $clog2(MAX_LEN + 1)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               On,
  input  logic [NUM_BTNS-1:0] Btn,
  output logic [9:0]         state,
  output logic               show_valid,
  output logic [CW-1:0]      show_color,
  output logic [LW-1:0]      level,
  output logic [SCORE_W-1:0] score
);

  localparam int PW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int T1   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TMAX = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = ((SCORE_W > LW) ? SCORE_W : LW) + 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW:0]   NB        = (CW + 1)'(NUM_BTNS);

  typedef enum logic [9:0] {
    S_IDLE     = 10'b00_0000_0001,
    S_GEN      = 10'b00_0000_0010,
    S_SHOW_ON  = 10'b00_0000_0100,
    S_SHOW_GAP = 10'b00_0000_1000,
    S_WAIT_IN  = 10'b00_0001_0000,
    S_RELEASE  = 10'b00_0010_0000,
    S_CHECK    = 10'b00_0100_0000,
    S_LOST     = 10'b00_1000_0000,
    S_WIN      = 10'b01_0000_0000,
    S_OFF      = 10'b10_0000_0000
  } state_t;

  state_t             st;
  logic [15:0]        lfsr;
  logic [CW-1:0]      seq [MAX_LEN];
  logic [PW-1:0]      pos;
  logic [PW-1:0]      play_idx;
  logic [CW-1:0]      b_idx;
  logic [TW-1:0]      timer;
  logic [CW-1:0]      raw_el;
  logic [CW-1:0]      new_el;
  logic [PW-1:0]      wr_idx;
  logic               btn_one;
  logic [CW-1:0]      btn_idx;

  // Score accumulation clamps at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [LW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({SCORE_W{1'b1}})) return '1;
    else return s[SCORE_W-1:0];
  endfunction

  assign state   = st;
  assign raw_el  = lfsr[CW-1:0];
  assign new_el  = ({1'b0, raw_el} >= NB) ? CW'({1'b0, raw_el} - NB) : raw_el;
  assign wr_idx  = PW'(level - LW'(1));
  assign btn_one = (Btn != '0) && ((Btn & (Btn - NUM_BTNS'(1))) == '0);

  // Index of the pressed button; only meaningful when exactly one bit is set.
  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_BTNS; i++)
      if (Btn[i]) btn_idx = CW'(i);
  end

  // Galois LFSR, taps x^16+x^14+x^13+x^11, stepping every cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) lfsr <= SEED;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Sequence storage: one element appended per round, never cleared.
  always_ff @(posedge Clk) begin
    if (st == S_GEN) seq[wr_idx] <= new_el;
  end

  // Game FSM with registered outputs; On low overrides every transition.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st         <= S_IDLE;
      show_valid <= 1'b0;
      show_color <= '0;
      level      <= '0;
      score      <= '0;
      pos        <= '0;
      play_idx   <= '0;
      b_idx      <= '0;
      timer      <= '0;
    end else begin
      show_valid <= 1'b0;
      if (!On && st != S_OFF) begin
        st <= S_OFF;
      end else begin
        case (st)
          S_IDLE: begin
            level <= LW'(1);
            score <= '0;
            pos   <= '0;
            if (Start && On) st <= S_GEN;
          end
          S_GEN: begin
            // The element written this cycle is not in seq yet, so a
            // first-round playback takes it straight from the LFSR.
            play_idx   <= '0;
            timer      <= '0;
            show_valid <= 1'b1;
            show_color <= (level == LW'(1)) ? new_el : seq[0];
            st         <= S_SHOW_ON;
          end
          S_SHOW_ON: begin
            if (timer == SHOW_LAST) begin
              timer <= '0;
              st    <= S_SHOW_GAP;
            end else begin
              timer      <= timer + TW'(1);
              show_valid <= 1'b1;
            end
          end
          S_SHOW_GAP: begin
            if (timer == GAP_LAST) begin
              timer <= '0;
              if (LW'(play_idx) < level - LW'(1)) begin
                play_idx   <= play_idx + PW'(1);
                show_color <= seq[play_idx + PW'(1)];
                show_valid <= 1'b1;
                st         <= S_SHOW_ON;
              end else begin
                pos <= '0;
                st  <= S_WAIT_IN;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_WAIT_IN: begin
            if (btn_one) begin
              b_idx <= btn_idx;
              st    <= S_RELEASE;
            end else if (TIMEOUT_CYCLES != 0 && timer == TO_LAST) begin
              st <= S_LOST;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_RELEASE: begin
            if (Btn == '0) st <= S_CHECK;
          end
          S_CHECK: begin
            if (b_idx != seq[pos]) begin
              st <= S_LOST;
            end else if (LW'(pos) < level - LW'(1)) begin
              pos   <= pos + PW'(1);
              timer <= '0;
              st    <= S_WAIT_IN;
            end else begin
              score <= sat_add(score, level);
              if (level == LW'(MAX_LEN)) begin
                st <= S_WIN;
              end else begin
                level <= level + LW'(1);
                pos   <= '0;
                st    <= S_GEN;
              end
            end
          end
          S_LOST, S_WIN, S_OFF: begin
            if (Start && On) st <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Bench for simon_seq_engine with a small configuration (4 buttons,
// 3-long sequence, 4/2 cycle playback, 20-cycle timeout).
module tb_simon_seq_engine;

  localparam logic [9:0] ST_IDLE = 10'd1,   ST_GEN  = 10'd2,   ST_SON  = 10'd4;
  localparam logic [9:0] ST_SGAP = 10'd8,   ST_WAIT = 10'd16,  ST_REL  = 10'd32;
  localparam logic [9:0] ST_CHK  = 10'd64,  ST_LOST = 10'd128, ST_WIN  = 10'd256;
  localparam logic [9:0] ST_OFF  = 10'd512;

  logic       Clk = 1'b0;
  logic       Reset, Start, On;
  logic [3:0] Btn;
  logic [9:0] state;
  logic       show_valid;
  logic [1:0] show_color;
  logic [1:0] level;
  logic [8:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] lfsr_m;
  logic [1:0]  exp_seq [3];
  logic [1:0]  seen    [3];
  logic [1:0]  gen_elem;
  logic [1:0]  wc;

  typedef struct {
    logic       start;
    logic       on;
    logic [3:0] btn;
    logic [9:0] st;
    logic       sv;
    logic [1:0] lvl;
    logic [8:0] sc;
  } vec_t;

  vec_t vt [15];

  simon_seq_engine #(
    .NUM_BTNS(4), .MAX_LEN(3), .SHOW_CYCLES(4), .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(20), .SCORE_W(9), .SEED(16'hACE1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .On(On), .Btn(Btn),
    .state(state), .show_valid(show_valid), .show_color(show_color),
    .level(level), .score(score)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: x^16+x^14+x^13+x^11 Galois form, seeded on reset.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  function automatic vec_t mk(input logic s, input logic o, input logic [3:0] b,
                              input logic [9:0] st, input logic sv,
                              input logic [1:0] l, input logic [8:0] sc);
    vec_t v;
    v.start = s; v.on = o; v.btn = b; v.st = st; v.sv = sv; v.lvl = l; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Start = 1'b0; Btn = 4'b0; On = 1'b1; Reset = 1'b1;
    #1;
    chk("reset_state", state, ST_IDLE);
    chk("reset_outs", {show_valid, show_color, level, score}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Caller has just observed GEN; records playback until WAIT_IN.
  task automatic run_playback(input int L);
    int n, cyc;
    logic prev;
    n = 0; cyc = 0; prev = 1'b0;
    exp_seq[L-1] = lfsr_m[1:0];
    while (state != ST_WAIT && cyc < 100) begin
      tick();
      cyc++;
      if (show_valid && !prev) begin
        if (n < 3) seen[n] = show_color;
        n++;
      end
      prev = show_valid;
    end
    chk("playback_reach_wait", state, ST_WAIT);
    chk("playback_cycles", cyc, 1 + L * 6);
    chk("playback_count", n, L);
    for (int i = 0; i < L; i++)
      chk($sformatf("playback_color%0d", i), seen[i], exp_seq[i]);
  endtask

  task automatic press(input logic [1:0] c, input logic [9:0] nst,
                       input logic [1:0] nl, input logic [8:0] nsc);
    Btn = 4'b0001 << c;
    tick();
    chk("press_to_release", state, ST_REL);
    Btn = 4'b0;
    tick();
    chk("release_to_check", state, ST_CHK);
    tick();
    chk("check_next", {state, level, score}, {nst, nl, nsc});
  endtask

  task automatic play_round(input int L, input logic [8:0] sc);
    for (int i = 0; i < L; i++) begin
      if (i < L - 1) press(exp_seq[i], ST_WAIT, 2'(L), sc);
      else if (L == 3) press(exp_seq[i], ST_WIN, 2'(L), sc + 9'(L));
      else press(exp_seq[i], ST_GEN, 2'(L + 1), sc + 9'(L));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0, 1, 4'b0000, ST_IDLE, 0, 1, 0);
    vt[1]  = mk(1, 1, 4'b0000, ST_GEN,  0, 1, 0);
    vt[2]  = mk(0, 1, 4'b0000, ST_SON,  1, 1, 0);
    vt[3]  = mk(0, 1, 4'b0000, ST_SON,  1, 1, 0);
    vt[4]  = mk(0, 1, 4'b0000, ST_SON,  1, 1, 0);
    vt[5]  = mk(0, 1, 4'b0000, ST_SON,  1, 1, 0);
    vt[6]  = mk(0, 1, 4'b0000, ST_SGAP, 0, 1, 0);
    vt[7]  = mk(0, 1, 4'b0000, ST_SGAP, 0, 1, 0);
    vt[8]  = mk(0, 1, 4'b0000, ST_WAIT, 0, 1, 0);
    vt[9]  = mk(0, 1, 4'b0101, ST_WAIT, 0, 1, 0);
    vt[10] = mk(0, 1, 4'b0011, ST_WAIT, 0, 1, 0);
    vt[11] = mk(0, 1, 4'b0000, ST_WAIT, 0, 1, 0);
    vt[12] = mk(0, 1, 4'b0100, ST_REL,  0, 1, 0);
    vt[13] = mk(0, 1, 4'b0100, ST_REL,  0, 1, 0);
    vt[14] = mk(0, 1, 4'b0000, ST_CHK,  0, 1, 0);

    do_reset();
    gen_elem = 2'd0;
    for (int i = 0; i < 15; i++) begin
      Start = vt[i].start; On = vt[i].on; Btn = vt[i].btn;
      tick();
      chk($sformatf("vec%0d", i), {state, show_valid, level, score},
          {vt[i].st, vt[i].sv, vt[i].lvl, vt[i].sc});
      if (vt[i].st == ST_GEN) gen_elem = lfsr_m[1:0];
      if (vt[i].sv) chk($sformatf("vec%0d_color", i), show_color, gen_elem);
    end
    // b_idx=2 was latched; outcome depends on whether colour 2 was shown.
    tick();
    if (gen_elem == 2'd2) chk("bidx2_outcome", {state, level, score}, {ST_GEN, 2'd2, 9'd1});
    else                  chk("bidx2_outcome", {state, level, score}, {ST_LOST, 2'd1, 9'd0});

    // Full game to WIN.
    do_reset();
    Start = 1'b1; tick(); Start = 1'b0;
    chk("win_gen1", state, ST_GEN);
    run_playback(1); play_round(1, 9'd0);
    run_playback(2); play_round(2, 9'd1);
    run_playback(3); play_round(3, 9'd3);
    tick();
    chk("win_hold", {state, level, score}, {ST_WIN, 2'd3, 9'd6});

    // Restart, then a wrong press in round 1.
    Start = 1'b1; tick();
    chk("win_to_idle", state, ST_IDLE);
    tick(); Start = 1'b0;
    chk("restart_gen", {state, level, score}, {ST_GEN, 2'd1, 9'd0});
    run_playback(1);
    wc = exp_seq[0] + 2'd1;
    press(wc, ST_LOST, 2'd1, 9'd0);
    tick();
    chk("lost_hold", state, ST_LOST);
    Start = 1'b1; tick();
    chk("lost_to_idle", {state, level, score}, {ST_IDLE, 2'd1, 9'd0});
    tick(); Start = 1'b0;
    chk("lost_restart_gen", state, ST_GEN);

    // Input timeout after 20 idle WAIT_IN cycles.
    run_playback(1);
    for (int i = 0; i < 19; i++) tick();
    chk("timeout_not_yet", state, ST_WAIT);
    tick();
    chk("timeout_lost", state, ST_LOST);

    // A held button does not time out.
    Start = 1'b1; tick(); tick(); Start = 1'b0;
    chk("hold_gen", state, ST_GEN);
    run_playback(1);
    Btn = 4'b0001 << exp_seq[0];
    for (int i = 0; i < 30; i++) tick();
    chk("hold_release", state, ST_REL);
    Btn = 4'b0; tick();
    chk("hold_check", state, ST_CHK);
    tick();
    chk("hold_advance", {state, level, score}, {ST_GEN, 2'd2, 9'd1});

    // Reset asserted during CHECK takes effect without a clock edge.
    run_playback(2);
    Btn = 4'b0001 << exp_seq[0]; tick();
    Btn = 4'b0; tick();
    chk("midreset_in_check", state, ST_CHK);
    #2 Reset = 1'b1;
    #1;
    chk("midreset_state", state, ST_IDLE);
    chk("midreset_outs", {show_valid, show_color, level, score}, 32'h0);
    On = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    tick();
    chk("off_after_reset", state, ST_OFF);

    // Power switch dropped during playback.
    On = 1'b1; Start = 1'b1; tick();
    chk("off_to_idle", state, ST_IDLE);
    tick(); Start = 1'b0;
    chk("on_gen", state, ST_GEN);
    tick();
    chk("on_show", {state, show_valid}, {ST_SON, 1'b1});
    On = 1'b0; tick();
    chk("drop_on_off", {state, show_valid}, {ST_OFF, 1'b0});
    Start = 1'b1; tick();
    chk("off_needs_on", state, ST_OFF);
    On = 1'b1; tick(); Start = 1'b0;
    chk("off_restart", state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_seq_engine.md
# simon_seq_engine

Parametrised game engine for the Simon-style memory game. It replaces the fixed 4-colour, 10-round, regenerate-each-round controller with a synthesizable design that has:
- a configurable number of buttons and a configurable maximum sequence length;
- an LFSR-driven sequence that grows by one element per round;
- a timed playback phase and an input timeout.

It sits between the debounced board buttons/switches and the VGA/SSD display logic, which consume its one-hot state, playback colour, level and score.

## Interface
- NUM_BTNS, 4: number of colour buttons (2..8); colour index width CW = clog2(NUM_BTNS)
- MAX_LEN, 16: longest sequence; reaching it and completing the round wins
- SHOW_CYCLES, 25_000_000: cycles each colour is displayed during playback
- GAP_CYCLES, 12_500_000: dark cycles between displayed colours
- TIMEOUT_CYCLES, 250_000_000: max WAIT_IN cycles before loss; 0 disables timeout
- SCORE_W, 9: score width
- SEED, 16'hACE1: LFSR reset value (nonzero)

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Start  in  1  level-sensitive start/restart request
- On  in  1  power switch (SW0); low forces OFF
- Btn  in  NUM_BTNS  debounced buttons, bit i = colour i
- state  out  10  one-hot {OFF,WIN,LOST,CHECK,RELEASE,WAIT_IN,SHOW_GAP,SHOW_ON,GEN,IDLE}, IDLE = bit 0
- show_valid  out  1  high while a playback colour is displayed
- show_color  out  CW  colour index being displayed
- level  out  clog2(MAX_LEN+1)  current sequence length
- score  out  SCORE_W  accumulated score, saturating

## Operation
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every cycle and is reset to SEED. New element = lfsr[CW-1:0], minus NUM_BTNS if that is >= NUM_BTNS.
- Sequence RAM: MAX_LEN x CW registers. Contents are not cleared by reset. Index pos tracks the player's position.
- IDLE: level=1, score=0, pos=0. Start&&On -> GEN.
- GEN (1 cycle): seq[level-1] <= new element -> SHOW_ON with playback index p=0.
- SHOW_ON: show_valid=1, show_color=seq[p] for SHOW_CYCLES cycles -> SHOW_GAP.
- SHOW_GAP: show_valid=0 for GAP_CYCLES cycles. Then p++ -> SHOW_ON if p<level-1, else -> WAIT_IN with pos=0 and timer=0.
- WAIT_IN:
  - exactly one Btn bit set -> latch its index into b_idx -> RELEASE.
  - zero or multiple bits set -> stay.
  - timer reaches TIMEOUT_CYCLES (nonzero) -> LOST.
- RELEASE: wait for Btn==0 -> CHECK.
- CHECK (1 cycle):
  - b_idx != seq[pos] -> LOST.
  - match and pos<level-1 -> pos++ -> WAIT_IN with timer=0.
  - match and pos==level-1 -> score += level, saturating at all-ones. Then, if level==MAX_LEN -> WIN; else level++, pos=0 -> GEN.
- LOST / WIN: hold level and score. Start&&On -> IDLE.
- OFF: show_valid=0. Start&&On -> IDLE.
- On low in any state except OFF -> OFF next cycle. This overrides every other transition, including CHECK.
- Illegal state encoding -> IDLE next cycle.

## Timing
- Reset values: state=IDLE (bit 0), show_valid=0, show_color=0, level=0, score=0, pos=0, timers=0, lfsr=SEED.
- Reset asserted mid-game returns to IDLE asynchronously. If On is low, OFF follows one cycle after Reset deasserts.
- Start sampled in IDLE: GEN on the next edge, first show_valid rise one cycle later.
- Playback length: GEN to WAIT_IN is 1 + level*(SHOW_CYCLES+GAP_CYCLES) cycles.
- Button response:
  - press -> RELEASE in 1 cycle.
  - release -> CHECK in 1 cycle.
  - CHECK -> next state in 1 cycle.
- A press and release in the same cycle is impossible, because RELEASE always lasts at least one cycle.
- The timer counts only in WAIT_IN and does not count in RELEASE. A held button cannot time out.
- Start held continuously restarts: LOST -> IDLE -> GEN on consecutive cycles.
- Outputs are registered; state bits are a direct register view.

## Test plan
Parameters: NUM_BTNS=4, MAX_LEN=3, SHOW=4, GAP=2, TIMEOUT=20, SEED=16'hACE1. The bench records show_color.
- Reset, On=1, Start pulse -> GEN, then show_valid high exactly 4 cycles with one colour, then WAIT_IN at cycle 1+6=7. level=1, score=0.
- Play back the correct colours for 3 rounds -> score 1, 3, 6; level reaches 3; state=WIN. Round 2 replays seq[0] unchanged before the new element.
- Press a wrong button in round 1 -> LOST with score=0. Start -> IDLE, level=1, score=0.
- Leave WAIT_IN idle for 20 cycles -> LOST. Hold a button 30 cycles, then release correctly -> no timeout, advance.
- Press Btn=4'b0101 in WAIT_IN -> stay in WAIT_IN. Then 4'b0100 -> RELEASE with b_idx=2.
- Drop On during SHOW_ON -> OFF next cycle, show_valid=0. Assert Reset mid-CHECK -> IDLE immediately with all outputs at reset values.
